// File: rtl/serial_bridge_pkg.sv
// Shared constants and types for the serial bridge between the processor's
// serial I/O port and the external byte link.
package serial_bridge_pkg;

  localparam int          SERIAL_BYTE_W             = 8;
  localparam logic [31:0] SERIAL_IO_ADDR            = 32'hFFFF_0000;
  localparam int          SERIAL_FIFO_DEPTH_DEFAULT = 16;

  typedef logic [SERIAL_BYTE_W-1:0] byte_t;

endpackage

// File: rtl/serial_bridge_if.sv
// Processor-side and link-side byte handshakes of serial_bridge.
// The slave modport is the bridge itself; master is whatever drives it.
interface serial_bridge_if;
  import serial_bridge_pkg::*;

  byte_t cpu_rx_data_out;
  logic  cpu_rx_valid_out;
  logic  cpu_rx_rden_in;
  byte_t cpu_tx_data_in;
  logic  cpu_tx_wren_in;
  logic  cpu_tx_ready_out;
  byte_t ext_rx_data_in;
  logic  ext_rx_valid_in;
  logic  ext_rx_ready_out;
  byte_t ext_tx_data_out;
  logic  ext_tx_valid_out;
  logic  ext_tx_ready_in;
  logic  tx_overflow_out;
  logic  rx_underflow_out;

  modport slave (
    output cpu_rx_data_out, cpu_rx_valid_out, cpu_tx_ready_out,
           ext_rx_ready_out, ext_tx_data_out, ext_tx_valid_out,
           tx_overflow_out, rx_underflow_out,
    input  cpu_rx_rden_in, cpu_tx_data_in, cpu_tx_wren_in,
           ext_rx_data_in, ext_rx_valid_in, ext_tx_ready_in
  );

  modport master (
    input  cpu_rx_data_out, cpu_rx_valid_out, cpu_tx_ready_out,
           ext_rx_ready_out, ext_tx_data_out, ext_tx_valid_out,
           tx_overflow_out, rx_underflow_out,
    output cpu_rx_rden_in, cpu_tx_data_in, cpu_tx_wren_in,
           ext_rx_data_in, ext_rx_valid_in, ext_tx_ready_in
  );

endinterface

// File: rtl/serial_bridge_byte_fifo.sv
// Byte FIFO with registered occupancy count; full/empty derive from the count.
// Head data is read combinationally and forced to zero when empty.
module byte_fifo
  import serial_bridge_pkg::*;
#(
  parameter  int DEPTH = SERIAL_FIFO_DEPTH_DEFAULT,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = CNT_W - 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  byte_t            wdata,
  input  logic             pop,
  output byte_t            rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  byte_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; pointers and count alone define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/serial_bridge.sv
// RX/TX byte buffering between the processor serial port and the external link.
// Define SERIAL_BRIDGE_LOOPBACK_EN to add loopback_in, which steers TX bytes back into RX.
module serial_bridge
  import serial_bridge_pkg::*;
#(
  parameter int DEPTH = SERIAL_FIFO_DEPTH_DEFAULT
) (
  input  logic           clock,
  input  logic           reset_n,
`ifdef SERIAL_BRIDGE_LOOPBACK_EN
  input  logic           loopback_in,
`endif
  serial_bridge_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             rx_push, rx_full, rx_empty;
  byte_t            rx_wdata, rx_rdata;
  logic [CNT_W-1:0] rx_count;
  logic             tx_pop, tx_full, tx_empty;
  byte_t            tx_rdata;
  logic [CNT_W-1:0] tx_count;
  logic             tx_overflow_q, rx_underflow_q;

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (rx_push),
    .wdata  (rx_wdata),
    .pop    (bus.cpu_rx_rden_in),
    .rdata  (rx_rdata),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (bus.cpu_tx_wren_in),
    .wdata  (bus.cpu_tx_data_in),
    .pop    (tx_pop),
    .rdata  (tx_rdata),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

`ifdef SERIAL_BRIDGE_LOOPBACK_EN
  logic lb_q;
  logic lb_move;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lb_q <= 1'b0;
    else          lb_q <= loopback_in;
  end

  // In loopback the link is fenced off on both sides and TX feeds RX directly.
  assign lb_move              = lb_q && !tx_empty && !rx_full;
  assign rx_push              = lb_q ? lb_move  : bus.ext_rx_valid_in;
  assign rx_wdata             = lb_q ? tx_rdata : bus.ext_rx_data_in;
  assign tx_pop               = lb_q ? lb_move  : bus.ext_tx_ready_in;
  assign bus.ext_tx_valid_out = !tx_empty && !lb_q;
  assign bus.ext_rx_ready_out = !rx_full && !lb_q;
`else
  assign rx_push              = bus.ext_rx_valid_in;
  assign rx_wdata             = bus.ext_rx_data_in;
  assign tx_pop               = bus.ext_tx_ready_in;
  assign bus.ext_tx_valid_out = !tx_empty;
  assign bus.ext_rx_ready_out = !rx_full;
`endif

  assign bus.cpu_rx_data_out  = rx_rdata;
  assign bus.cpu_rx_valid_out = !rx_empty;
  assign bus.cpu_tx_ready_out = !tx_full;
  assign bus.ext_tx_data_out  = tx_rdata;
  assign bus.tx_overflow_out  = tx_overflow_q;
  assign bus.rx_underflow_out = rx_underflow_q;

  // Error flags are sticky until reset; the processor has no back-pressure to honour.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_overflow_q  <= 1'b0;
      rx_underflow_q <= 1'b0;
    end else begin
      if (bus.cpu_tx_wren_in && tx_count == CNT_W'(DEPTH)) tx_overflow_q  <= 1'b1;
      if (bus.cpu_rx_rden_in && rx_count == '0)            rx_underflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_bridge.sv
// Directed and randomized checks of serial_bridge against a queue-based model
// of the two FIFOs and their sticky error flags.
module tb_serial_bridge;
  import serial_bridge_pkg::*;

  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  serial_bridge_if bus ();
`ifdef SERIAL_BRIDGE_LOOPBACK_EN
  logic loopback_in = 1'b0;
`endif

  serial_bridge #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
`ifdef SERIAL_BRIDGE_LOOPBACK_EN
    .loopback_in(loopback_in),
`endif
    .bus        (bus)
  );

  byte_t rxq[$];
  byte_t txq[$];
  bit    ovf_m;
  bit    unf_m;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    byte_t e_rx, e_tx;
    e_rx = (rxq.size() != 0) ? rxq[0] : 8'h00;
    e_tx = (txq.size() != 0) ? txq[0] : 8'h00;
    check({ph, "_rx_valid"},  8'(bus.cpu_rx_valid_out), 8'(rxq.size() != 0));
    check({ph, "_rx_data"},   bus.cpu_rx_data_out,      e_rx);
    check({ph, "_tx_ready"},  8'(bus.cpu_tx_ready_out), 8'(txq.size() < DEPTH));
    check({ph, "_ext_rdy"},   8'(bus.ext_rx_ready_out), 8'(rxq.size() < DEPTH));
    check({ph, "_ext_valid"}, 8'(bus.ext_tx_valid_out), 8'(txq.size() != 0));
    check({ph, "_ext_data"},  bus.ext_tx_data_out,      e_tx);
    check({ph, "_overflow"},  8'(bus.tx_overflow_out),  8'(ovf_m));
    check({ph, "_underflow"}, 8'(bus.rx_underflow_out), 8'(unf_m));
  endtask

  // One clock cycle: drive inputs, advance the model from pre-edge state, then check.
  task automatic step(input string ph, input logic erv, input byte_t erd, input logic rden,
                      input logic wren, input byte_t twd, input logic etr);
    bit rx_has, rx_room, tx_has, tx_room;
    bus.ext_rx_valid_in = erv;
    bus.ext_rx_data_in  = erd;
    bus.cpu_rx_rden_in  = rden;
    bus.cpu_tx_wren_in  = wren;
    bus.cpu_tx_data_in  = twd;
    bus.ext_tx_ready_in = etr;
    rx_has  = rxq.size() > 0;
    rx_room = rxq.size() < DEPTH;
    tx_has  = txq.size() > 0;
    tx_room = txq.size() < DEPTH;
    if (rden) begin
      if (rx_has) void'(rxq.pop_front());
      else        unf_m = 1'b1;
    end
    if (erv && rx_room) rxq.push_back(erd);
    if (etr && tx_has) void'(txq.pop_front());
    if (wren) begin
      if (tx_room) txq.push_back(twd);
      else         ovf_m = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
    check_all(ph);
  endtask

  task automatic idle(input string ph);
    step(ph, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_model();
    rxq.delete();
    txq.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  task automatic do_reset(input string ph);
    bus.ext_rx_valid_in = 1'b0;
    bus.cpu_rx_rden_in  = 1'b0;
    bus.cpu_tx_wren_in  = 1'b0;
    bus.ext_tx_ready_in = 1'b0;
    reset_n = 1'b0;
    clear_model();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all({ph, "_held"});
    reset_n = 1'b1;
    idle({ph, "_released"});
  endtask

  initial begin
    bit seen;
    bus.ext_rx_valid_in = 1'b0;
    bus.ext_rx_data_in  = 8'h00;
    bus.cpu_rx_rden_in  = 1'b0;
    bus.cpu_tx_wren_in  = 1'b0;
    bus.cpu_tx_data_in  = 8'h00;
    bus.ext_tx_ready_in = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);

    // 1: reset state
    do_reset("t1");

    // 2: two link bytes, then two processor pops
    step("t2_push41", 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t2_head41", bus.cpu_rx_data_out, 8'h41);
    step("t2_push42", 1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0);
    step("t2_pop1",   1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    check("t2_head42", bus.cpu_rx_data_out, 8'h42);
    step("t2_pop2",   1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    check("t2_empty", 8'(bus.cpu_rx_valid_out), 8'h00);

    // 3: fill TX past capacity with the link stalled, then drain
    for (int i = 0; i <= DEPTH; i++) begin
      step("t3_wr", 1'b0, 8'h00, 1'b0, 1'b1, byte_t'(i), 1'b0);
      if (i == DEPTH - 1) check("t3_full_ready", 8'(bus.cpu_tx_ready_out), 8'h00);
    end
    check("t3_overflow", 8'(bus.tx_overflow_out), 8'h01);
    for (int i = 0; i < DEPTH; i++) begin
      check("t3_drain_data", bus.ext_tx_data_out, byte_t'(i));
      step("t3_drain", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    check("t3_drained", 8'(bus.ext_tx_valid_out), 8'h00);

    // 4: simultaneous push/pop at count 1, then underflow
    do_reset("t4_rst");
    step("t4_push33", 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0);
    step("t4_pushpop", 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
    check("t4_head55", bus.cpu_rx_data_out, 8'h55);
    step("t4_pop", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step("t4_underflow", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    check("t4_unf_flag", 8'(bus.rx_underflow_out), 8'h01);
    step("t4_push66", 1'b1, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0);
    check("t4_head66", bus.cpu_rx_data_out, 8'h66);

    // 5: asynchronous reset mid-stream
    for (int i = 0; i < 5; i++)
      step("t5_fill", 1'b1, byte_t'(8'h10 + i), 1'b0, 1'b1, byte_t'(8'h20 + i), 1'b0);
    #2 reset_n = 1'b0;
    clear_model();
    #1 check_all("t5_async");
    do_reset("t5_rst");

`ifdef SERIAL_BRIDGE_LOOPBACK_EN
    // 6: loopback steers a processor byte back to RX without touching the link
    loopback_in = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.cpu_tx_wren_in = 1'b1;
    bus.cpu_tx_data_in = 8'hA5;
    @(posedge clock);
    @(negedge clock);
    bus.cpu_tx_wren_in = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3 && !seen; k++) begin
      check("t6_ext_tx_valid", 8'(bus.ext_tx_valid_out), 8'h00);
      check("t6_ext_rx_ready", 8'(bus.ext_rx_ready_out), 8'h00);
      if (bus.cpu_rx_valid_out === 1'b1 && bus.cpu_rx_data_out === 8'hA5) seen = 1'b1;
      else begin
        @(posedge clock);
        @(negedge clock);
      end
    end
    check("t6_looped", 8'(seen), 8'h01);
    loopback_in = 1'b0;
    do_reset("t6_rst");
`endif

    // Randomized traffic alternating between filling and draining bias
    for (int c = 0; c < 400; c++) begin
      bit fill;
      fill = ((c / 50) % 2) == 0;
      step("rnd",
           $urandom_range(0, 99) < (fill ? 85 : 30), byte_t'($urandom),
           $urandom_range(0, 99) < (fill ? 20 : 75),
           $urandom_range(0, 99) < (fill ? 85 : 30), byte_t'($urandom),
           $urandom_range(0, 99) < (fill ? 20 : 75));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
